// File: rtl/req_pkg.sv
// rtl/req_pkg.sv - shared widths and FSM encoding for the request arbiter
package req_pkg;

    localparam int REQ_W = 32;
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        ACCEPT = 2'd1,
        SEND   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first valid index at or after rr_ptr
module rr_pick
    import req_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    int                   off;
    int                   sum;

    // Rotate so rr_ptr lands on bit 0, then the lowest set bit is the winner.
    always_comb begin
        dbl   = {valid, valid} >> rr_ptr;
        rot   = dbl[NUM_REQ-1:0];
        off   = 0;
        any   = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = k;
                any = 1'b1;
            end
        end
        sum = int'(rr_ptr) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        grant = IDX_W'(sum);
    end

endmodule

// File: rtl/req_arbiter.sv
// rtl/req_arbiter.sv - round-robin arbiter with outstanding-credit throttle feeding the RQ stream
module req_arbiter
    import req_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     enable,
    input  logic [REQ_W*NUM_REQ-1:0] AXIS_IN_TDATA,
    input  logic [NUM_REQ-1:0]       AXIS_IN_TVALID,
    output logic [NUM_REQ-1:0]       AXIS_IN_TREADY,
    output logic [REQ_W-1:0]         AXIS_RQ_TDATA,
    output logic [IDX_W-1:0]         AXIS_RQ_TUSER,
    output logic                     AXIS_RQ_TVALID,
    input  logic                     AXIS_RQ_TREADY,
    input  logic                     cmpl_strobe,
    output logic [7:0]               outstanding,
    output logic                     busy,
    output logic                     cmpl_err
);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] tready_q, tready_d;
    logic [REQ_W-1:0]   tdata_q, tdata_d;
    logic [IDX_W-1:0]   tuser_q, tuser_d;
    logic               tvalid_q, tvalid_d;
    logic [7:0]         out_q, out_d;
    logic               err_q, err_d;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [REQ_W-1:0]   in_word;
    logic               credit_ok;
    logic               grant_fire;
    logic               in_fire;
    logic               rq_fire;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .valid  (AXIS_IN_TVALID),
        .rr_ptr (rr_ptr_q),
        .grant  (pick_idx),
        .any    (pick_any)
    );

    assign credit_ok = (out_q < 8'(MAX_OUTSTANDING));
    // tready_q is one-hot on the granted requester, so masking selects its handshake.
    assign in_fire   = |(AXIS_IN_TVALID & tready_q);
    assign rq_fire   = tvalid_q & AXIS_RQ_TREADY;

    always_comb begin
        in_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tready_q[i]) begin
                in_word = AXIS_IN_TDATA[i*REQ_W +: REQ_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        tready_d   = tready_q;
        tdata_d    = tdata_q;
        tuser_d    = tuser_q;
        tvalid_d   = tvalid_q;
        grant_fire = 1'b0;
        case (state_q)
            ARB: begin
                tready_d = '0;
                if (enable && credit_ok && pick_any) begin
                    grant_d    = pick_idx;
                    tready_d   = NUM_REQ'(1) << pick_idx;
                    grant_fire = 1'b1;
                    state_d    = ACCEPT;
                end
            end
            ACCEPT: begin
                if (in_fire) begin
                    tdata_d  = in_word;
                    tuser_d  = grant_q;
                    tready_d = '0;
                    tvalid_d = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (rq_fire) begin
                    tvalid_d = 1'b0;
                    rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
                    state_d  = ARB;
                end
            end
            default: begin
                tready_d = '0;
                tvalid_d = 1'b0;
                state_d  = ARB;
            end
        endcase
    end

    // Credit is taken at grant; a coincident completion cancels it out.
    always_comb begin
        out_d = out_q;
        err_d = err_q;
        if (grant_fire && !cmpl_strobe) begin
            out_d = out_q + 8'd1;
        end else if (!grant_fire && cmpl_strobe) begin
            if (out_q == 8'd0) begin
                err_d = 1'b1;
            end else begin
                out_d = out_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ARB;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            tready_q <= '0;
            tdata_q  <= '0;
            tuser_q  <= '0;
            tvalid_q <= 1'b0;
            out_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            tready_q <= tready_d;
            tdata_q  <= tdata_d;
            tuser_q  <= tuser_d;
            tvalid_q <= tvalid_d;
            out_q    <= out_d;
            err_q    <= err_d;
        end
    end

    assign AXIS_IN_TREADY = tready_q;
    assign AXIS_RQ_TDATA  = tdata_q;
    assign AXIS_RQ_TUSER  = tuser_q;
    assign AXIS_RQ_TVALID = tvalid_q;
    assign outstanding    = out_q;
    assign cmpl_err       = err_q;
    assign busy           = (state_q != ARB) || (out_q != 8'd0);

endmodule

// File: tb/tb_req_arbiter.sv
// tb/tb_req_arbiter.sv - self-checking bench for req_arbiter
module tb_req_arbiter;

    localparam int N   = 4;
    localparam int MAX = 2;

    logic           clk = 1'b0;
    logic           resetn;
    logic           enable;
    logic [32*N-1:0] in_tdata;
    logic [N-1:0]   in_tvalid;
    logic [N-1:0]   in_tready;
    logic [31:0]    rq_tdata;
    logic [3:0]     rq_tuser;
    logic           rq_tvalid;
    logic           rq_tready;
    logic           cmpl;
    logic [7:0]     outstanding;
    logic           busy;
    logic           cmpl_err;

    int total = 0;
    int bad   = 0;
    int tr_cnt;
    logic [N-1:0] tr_seen;

    always #5 clk = ~clk;

    req_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(MAX)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .enable         (enable),
        .AXIS_IN_TDATA  (in_tdata),
        .AXIS_IN_TVALID (in_tvalid),
        .AXIS_IN_TREADY (in_tready),
        .AXIS_RQ_TDATA  (rq_tdata),
        .AXIS_RQ_TUSER  (rq_tuser),
        .AXIS_RQ_TVALID (rq_tvalid),
        .AXIS_RQ_TREADY (rq_tready),
        .cmpl_strobe    (cmpl),
        .outstanding    (outstanding),
        .busy           (busy),
        .cmpl_err       (cmpl_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tv(input int lim, output int n);
        n = 0;
        while (!rq_tvalid && n < lim) begin
            step();
            n++;
            if (in_tready != 0) begin
                tr_cnt++;
                tr_seen = in_tready;
            end
        end
        if (!rq_tvalid) begin
            total++;
            bad++;
            $display("FAIL wait_tvalid timed out after %0d cycles", n);
        end
    endtask

    function automatic int rr_first(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    typedef struct {
        logic [N-1:0] vld;
        int           exp_g;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int n, stage, owner, ptr_m, out_m;
        logic err_m, grant_now, acc_now, stable, quiet;
        logic [31:0] hold_d, d0;
        logic [3:0] u0;

        // Grant order follows from the pointer moving to one past each winner.
        tbl[0] = '{4'b1010, 1};
        tbl[1] = '{4'b0001, 0};
        tbl[2] = '{4'b1111, 1};
        tbl[3] = '{4'b0110, 2};
        tbl[4] = '{4'b0011, 0};
        tbl[5] = '{4'b1000, 3};
        tbl[6] = '{4'b1111, 0};
        tbl[7] = '{4'b0001, 0};
        tbl[8] = '{4'b1100, 2};

        resetn = 1'b0; enable = 1'b1; in_tdata = '0; in_tvalid = '0;
        rq_tready = 1'b1; cmpl = 1'b0;
        step(); step();
        chk("rst_in_tready", 32'(in_tready), 0);
        chk("rst_tvalid", 32'(rq_tvalid), 0);
        chk("rst_tdata", rq_tdata, 0);
        chk("rst_tuser", 32'(rq_tuser), 0);
        chk("rst_outstanding", 32'(outstanding), 0);
        chk("rst_cmpl_err", 32'(cmpl_err), 0);
        chk("rst_busy", 32'(busy), 0);
        resetn = 1'b1;
        step();

        for (int t = 0; t < 9; t++) begin
            for (int i = 0; i < N; i++) in_tdata[i*32 +: 32] = 32'hA000_0000 | (t << 8) | i;
            in_tvalid = tbl[t].vld;
            tr_cnt = 0; tr_seen = '0;
            wait_tv(6, n);
            chk($sformatf("vec%0d_latency", t), n, 2);
            chk($sformatf("vec%0d_tready_cycles", t), tr_cnt, 1);
            chk($sformatf("vec%0d_tready_who", t), 32'(tr_seen), 32'(1 << tbl[t].exp_g));
            chk($sformatf("vec%0d_tuser", t), 32'(rq_tuser), tbl[t].exp_g);
            chk($sformatf("vec%0d_tdata", t), rq_tdata, 32'hA000_0000 | (t << 8) | tbl[t].exp_g);
            chk($sformatf("vec%0d_outstanding", t), 32'(outstanding), 1);
            in_tvalid = '0;
            cmpl = 1'b1;
            step();
            cmpl = 1'b0;
        end

        // Credit limit: two issue, the third waits for a completion.
        in_tvalid = 4'hF;
        for (int c = 0; c < 12; c++) step();
        chk("credit_outstanding", 32'(outstanding), 2);
        chk("credit_busy", 32'(busy), 1);
        chk("credit_stall_tready", 32'(in_tready), 0);
        chk("credit_stall_tvalid", 32'(rq_tvalid), 0);
        cmpl = 1'b1;
        step();
        cmpl = 1'b0;
        n = 1;
        while (in_tready == 0 && n < 3) begin step(); n++; end
        chk("credit_release_grant", 32'(in_tready != 0), 1);
        wait_tv(4, n);
        in_tvalid = '0;
        step();
        cmpl = 1'b1;
        step(); step();
        cmpl = 1'b0;
        chk("credit_drained", 32'(outstanding), 0);

        // Backpressure held in SEND for 10 cycles.
        rq_tready = 1'b0;
        in_tdata[2*32 +: 32] = 32'h5A5A_0002;
        in_tvalid = 4'b0100;
        wait_tv(4, n);
        in_tvalid = 4'b1011;
        d0 = rq_tdata; u0 = rq_tuser;
        chk("bp_tdata", d0, 32'h5A5A_0002);
        chk("bp_tuser", 32'(u0), 2);
        stable = 1'b1; quiet = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (rq_tdata !== d0 || rq_tuser !== u0 || rq_tvalid !== 1'b1) stable = 1'b0;
            if (in_tready != 0) quiet = 1'b0;
        end
        chk("bp_stable", 32'(stable), 1);
        chk("bp_no_tready", 32'(quiet), 1);
        rq_tready = 1'b1;
        step();
        in_tvalid = '0;
        chk("bp_done", 32'(rq_tvalid), 0);
        chk("bp_outstanding", 32'(outstanding), 1);

        // Completion coincident with a grant at outstanding 1.
        in_tvalid = 4'b0001;
        cmpl = 1'b1;
        step();
        cmpl = 1'b0;
        chk("coinc_grant", 32'(in_tready), 1);
        chk("coinc_outstanding", 32'(outstanding), 1);
        step();
        in_tvalid = '0;
        wait_tv(3, n);
        step();
        cmpl = 1'b1;
        step();
        chk("cmpl_to_zero", 32'(outstanding), 0);
        chk("cmpl_err_clear", 32'(cmpl_err), 0);
        step();
        cmpl = 1'b0;
        chk("cmpl_err_set", 32'(cmpl_err), 1);
        chk("cmpl_err_count", 32'(outstanding), 0);
        step();
        chk("cmpl_err_sticky", 32'(cmpl_err), 1);

        // Asynchronous reset in SEND, then enable gating after release.
        rq_tready = 1'b0;
        in_tvalid = 4'b0010;
        wait_tv(4, n);
        in_tvalid = '0;
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_tvalid", 32'(rq_tvalid), 0);
        chk("async_rst_outstanding", 32'(outstanding), 0);
        enable = 1'b0; rq_tready = 1'b1;
        step(); step();
        resetn = 1'b1;
        in_tvalid = 4'b0010;
        quiet = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (in_tready != 0) quiet = 1'b0;
        end
        chk("disabled_no_grant", 32'(quiet), 1);
        enable = 1'b1;
        n = 0;
        while (in_tready == 0 && n < 3) begin step(); n++; end
        chk("enabled_grant", 32'(in_tready), 32'b0010);

        // Randomised traffic against a transaction-level model.
        resetn = 1'b0; in_tvalid = '0; cmpl = 1'b0; enable = 1'b1; rq_tready = 1'b1;
        step(); step();
        resetn = 1'b1;
        stage = 0; owner = 0; ptr_m = 0; out_m = 0; err_m = 1'b0; hold_d = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            grant_now = 1'b0; acc_now = 1'b0;
            case (stage)
                0: if (enable && out_m < MAX && in_tvalid != 0) begin
                    owner = rr_first(in_tvalid, ptr_m);
                    ptr_m = (owner + 1) % N;
                    stage = 1;
                    grant_now = 1'b1;
                end
                1: if (in_tvalid[owner]) begin
                    hold_d = in_tdata[owner*32 +: 32];
                    stage = 2;
                    acc_now = 1'b1;
                end
                default: if (rq_tready) stage = 0;
            endcase
            if (grant_now && !cmpl) out_m++;
            else if (!grant_now && cmpl) begin
                if (out_m == 0) err_m = 1'b1;
                else out_m--;
            end
            chk("rnd_tready", 32'(in_tready), (stage == 1) ? (1 << owner) : 0);
            chk("rnd_tvalid", 32'(rq_tvalid), 32'(stage == 2));
            if (stage == 2) begin
                chk("rnd_tdata", rq_tdata, hold_d);
                chk("rnd_tuser", 32'(rq_tuser), owner);
            end
            chk("rnd_outstanding", 32'(outstanding), out_m);
            chk("rnd_cmpl_err", 32'(cmpl_err), 32'(err_m));
            chk("rnd_busy", 32'(busy), 32'(stage != 0 || out_m != 0));
            if (acc_now) in_tvalid[owner] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!in_tvalid[i] && $urandom_range(3) == 0) begin
                    in_tvalid[i] = 1'b1;
                    in_tdata[i*32 +: 32] = $urandom;
                end
            end
            enable    = ($urandom_range(7) != 0);
            rq_tready = ($urandom_range(3) != 0);
            cmpl      = ($urandom_range(4) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
